// File: rtl/adc_hex_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_hex_pkg : state encoding and ASCII-hex helpers for adc_hex_frame_tx  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package adc_hex_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DIG   = 3'd2;
  localparam logic [2:0] ST_SEP   = 3'd3;
  localparam logic [2:0] ST_WAITS = 3'd4;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_UP = 8'h37;
  localparam logic [7:0] ASCII_A_LO = 8'h57;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nibble, input logic upper);
    logic [7:0] base;
    if (nibble < 4'd10)
      base = ASCII_0;
    else if (upper)
      base = ASCII_A_UP;
    else
      base = ASCII_A_LO;
    return base + {4'h0, nibble};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_hex_frame_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo : first-word fall-through FIFO with full/empty and fill count  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_wr_en & ~o_full;
  assign w_pop  = i_rd_en & ~o_empty;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == (c_aw+1)'(DEPTH));
  assign o_empty   = (r_wr_ptr == r_rd_ptr);

endmodule
`default_nettype wire

// File: rtl/adc_hex_frame_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_hex_frame_tx : packs ADC samples into framed ASCII-hex UART bytes    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module adc_hex_frame_tx
  import adc_hex_pkg::*;
#(
  parameter int         DATA_W    = 12,
  parameter int         NIBBLES   = 4,
  parameter int         CH_NUM    = 10,
  parameter logic [7:0] HEADER    = 8'h0A,
  parameter bit         SEP_EN    = 1'b0,
  parameter logic [7:0] SEP       = 8'h20,
  parameter bit         UPPER     = 1'b0,
  parameter int         BUF_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              tx_full,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int                 c_idx_w   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_idx_w-1:0] c_idx_top = c_idx_w'(NIBBLES - 1);
  localparam logic [7:0]         c_ch_last = 8'(CH_NUM - 1);
  localparam int                 c_ext_w   = 4 * NIBBLES;
  localparam int                 c_cnt_w   = $clog2(BUF_DEPTH) + 1;

  logic [2:0]         r_state;
  logic [2:0]         w_state_n;
  logic [c_idx_w-1:0] r_idx;
  logic [c_idx_w-1:0] w_idx_n;
  logic [7:0]         r_ch;
  logic [7:0]         w_ch_n;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [c_cnt_w-1:0] w_count;
  logic [DATA_W:0]    w_head;
  logic [c_ext_w-1:0] w_ext;
  logic [3:0]         w_nibble;

  logic               w_go;
  logic               w_ch_end;
  logic               w_end;
  logic               w_last_dig;
  logic [7:0]         w_byte;
  logic               w_done;
  logic               w_err;

  assign s_ready = ~w_full & ~reset;
  assign w_push  = s_valid & s_ready;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (w_push),
    .i_wr_data ({s_last, s_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_ext      = c_ext_w'(w_head[DATA_W-1:0]);
  assign w_nibble   = w_ext[{r_idx, 2'b00} +: 4];
  assign w_go       = ((r_state == ST_HDR) || (r_state == ST_DIG) || (r_state == ST_SEP)) && !tx_full;
  assign w_ch_end   = (r_ch == c_ch_last);
  assign w_end      = w_ch_end | w_head[DATA_W];
  assign w_last_dig = (r_idx == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_ch       <= '0;
      tx_wr      <= 1'b0;
      tx_data    <= 8'h00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_ch       <= w_ch_n;
      tx_wr      <= w_go;
      frame_done <= w_done;
      frame_err  <= w_err;
      if (w_go) tx_data <= w_byte;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_ch_n    = r_ch;
    w_pop     = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_n = ST_HDR;
      ST_HDR: begin
        if (w_go) begin
          w_state_n = ST_DIG;
          w_idx_n   = c_idx_top;
        end
      end
      ST_DIG: begin
        if (w_go) begin
          if (!w_last_dig) begin
            w_idx_n = r_idx - 1'b1;
          end else begin
            w_pop = 1'b1;
            if (w_end) begin
              w_ch_n    = '0;
              // The head entry leaves this cycle; a count of one means nothing else waits.
              w_state_n = (w_count == c_cnt_w'(1)) ? ST_IDLE : ST_HDR;
            end else begin
              w_ch_n    = r_ch + 8'd1;
              w_state_n = SEP_EN ? ST_SEP : ST_WAITS;
            end
          end
        end
      end
      ST_SEP:   if (w_go) w_state_n = ST_WAITS;
      ST_WAITS: begin
        if (!w_empty) begin
          w_state_n = ST_DIG;
          w_idx_n   = c_idx_top;
        end
      end
      default:  w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      ST_HDR: w_byte = HEADER;
      ST_DIG: begin
        w_byte = nib2ascii(w_nibble, UPPER);
        w_done = w_go & w_last_dig & w_end;
        w_err  = w_go & w_last_dig & (w_ch_end ^ w_head[DATA_W]);
      end
      ST_SEP: w_byte = SEP;
      default: w_byte = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_hex_frame_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adc_hex_frame_tx : directed self-checking bench for adc_hex_frame_tx  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_adc_hex_frame_tx;

  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_last;
  logic        tx_full;
  logic [15:0] s_data;

  logic       s_ready0, s_ready1, s_ready2, s_ready3;
  logic       tx_wr0, tx_wr1, tx_wr2, tx_wr3;
  logic [7:0] tx_data0, tx_data1, tx_data2, tx_data3;
  logic       frame_done0, frame_done1, frame_done2, frame_done3;
  logic       frame_err0, frame_err1, frame_err2, frame_err3;
  logic       all_rdy;

  int   n_total = 0;
  int   n_bad   = 0;
  int   viol    = 0;
  logic prev_full = 1'b0;

  logic [7:0] q0[$], q1[$], q2[$], q3[$], exp_q[$];
  int         done_q0[$], err_q0[$], done_q3[$], err_q3[$];

  string hex_lo = "0123456789abcdef";
  string hex_up = "0123456789ABCDEF";

  always #10 clk = ~clk;

  adc_hex_frame_tx u_dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data[11:0]),
    .s_last(s_last), .tx_full(tx_full), .tx_wr(tx_wr0), .tx_data(tx_data0),
    .frame_done(frame_done0), .frame_err(frame_err0)
  );

  adc_hex_frame_tx #(.UPPER(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data[11:0]),
    .s_last(s_last), .tx_full(tx_full), .tx_wr(tx_wr1), .tx_data(tx_data1),
    .frame_done(frame_done1), .frame_err(frame_err1)
  );

  adc_hex_frame_tx #(.DATA_W(16)) u_dut2 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .tx_full(tx_full), .tx_wr(tx_wr2), .tx_data(tx_data2),
    .frame_done(frame_done2), .frame_err(frame_err2)
  );

  adc_hex_frame_tx #(.SEP_EN(1'b1), .CH_NUM(3)) u_dut3 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data[11:0]),
    .s_last(s_last), .tx_full(tx_full), .tx_wr(tx_wr3), .tx_data(tx_data3),
    .frame_done(frame_done3), .frame_err(frame_err3)
  );

  assign all_rdy = s_ready0 & s_ready1 & s_ready2 & s_ready3;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_wr0) q0.push_back(tx_data0);
      if (tx_wr1) q1.push_back(tx_data1);
      if (tx_wr2) q2.push_back(tx_data2);
      if (tx_wr3) q3.push_back(tx_data3);
      if (frame_done0) done_q0.push_back(q0.size());
      if (frame_err0)  err_q0.push_back(q0.size());
      if (frame_done3) done_q3.push_back(q3.size());
      if (frame_err3)  err_q3.push_back(q3.size());
      if ((tx_wr0 | tx_wr1 | tx_wr2 | tx_wr3) && prev_full) viol++;
    end
    prev_full = tx_full;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsz(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [7:0] qbyte(input int id, input int i);
    if (i >= qsz(id)) return 8'h00;
    case (id)
      0: return q0[i];
      1: return q1[i];
      2: return q2[i];
      default: return q3[i];
    endcase
  endfunction

  function automatic int at(input iq_t q, input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  function automatic void e_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endfunction

  function automatic void e_smp(input logic [15:0] v, input bit up);
    for (int d = 3; d >= 0; d--) begin
      int n;
      n = int'((v >> (4 * d)) & 16'hF);
      exp_q.push_back(up ? 8'(hex_up[n]) : 8'(hex_lo[n]));
    end
  endfunction

  task automatic cmp_q(input string tag, input int id);
    int nd;
    nd = 0;
    check_eq({tag, "_len"}, qsz(id), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < qsz(id); i++)
      if (qbyte(id, i) !== exp_q[i]) nd++;
    check_eq({tag, "_diff"}, nd, 0);
  endtask

  task automatic wait_q(input int id, input int n);
    int t;
    t = 0;
    while (qsz(id) < n && t < 2000) begin
      tick();
      t++;
    end
    if (qsz(id) < n) check_eq("wait_timeout", qsz(id), n);
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int t;
    t = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!all_rdy && t < 2000) begin
      tick();
      t++;
    end
    if (!all_rdy) check_eq("send_timeout", all_rdy, 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); q2.delete(); q3.delete(); exp_q.delete();
    done_q0.delete(); err_q0.delete(); done_q3.delete(); err_q3.delete();
  endtask

  task automatic reset_dut();
    reset   = 1'b1;
    s_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    clear_q();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic rdy;
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; tx_full = 1'b0;
    tick();
    check_eq("rst_tx_wr", tx_wr0, 0);
    check_eq("rst_tx_data", tx_data0, 8'h00);
    check_eq("rst_done", frame_done0, 0);
    check_eq("rst_err", frame_err0, 0);
    check_eq("rst_ready_low", s_ready0, 0);
    reset = 1'b0;
    tick();
    check_eq("rst_ready_high", s_ready0, 1);
    clear_q();

    // Ten samples, last on the tenth.
    for (int i = 0; i < 10; i++) send(16'(i), i == 9);
    wait_q(0, 41);
    repeat (5) tick();
    e_byte(8'h0A);
    for (int i = 0; i < 10; i++) e_smp(16'(i), 1'b0);
    cmp_q("p1", 0);
    check_eq("p1_done_n", done_q0.size(), 1);
    check_eq("p1_done_at", at(done_q0, 0), 41);
    check_eq("p1_err_n", err_q0.size(), 0);

    // Digit case and 16-bit width.
    reset_dut();
    send(16'h0ABC, 1'b1);
    send(16'hF00D, 1'b1);
    wait_q(0, 10); wait_q(1, 10); wait_q(2, 10);
    repeat (5) tick();
    e_byte(8'h0A); e_smp(16'h0ABC, 1'b0); e_byte(8'h0A); e_smp(16'h000D, 1'b0);
    cmp_q("p2_lo", 0);
    exp_q.delete();
    e_byte(8'h0A); e_smp(16'h0ABC, 1'b1); e_byte(8'h0A); e_smp(16'h000D, 1'b1);
    cmp_q("p2_up", 1);
    exp_q.delete();
    e_byte(8'h0A); e_smp(16'h0ABC, 1'b0); e_byte(8'h0A); e_smp(16'hF00D, 1'b0);
    cmp_q("p2_w16", 2);

    // Separator, three channels.
    reset_dut();
    send(16'h1, 1'b0); send(16'h2, 1'b0); send(16'h3, 1'b1);
    wait_q(3, 15);
    repeat (5) tick();
    e_byte(8'h0A); e_smp(16'h1, 1'b0); e_byte(8'h20); e_smp(16'h2, 1'b0);
    e_byte(8'h20); e_smp(16'h3, 1'b0);
    cmp_q("p3", 3);
    check_eq("p3_done_at", at(done_q3, 0), 15);
    check_eq("p3_err_n", err_q3.size(), 0);

    // Backpressure every third byte.
    reset_dut();
    fork
      begin
        for (int i = 0; i < 10; i++) send(16'(i), i == 9);
      end
      begin
        for (int m = 3; m <= 39; m += 3) begin
          wait_q(0, m);
          tx_full = 1'b1;
          repeat (5) tick();
          tx_full = 1'b0;
        end
      end
    join
    wait_q(0, 41);
    repeat (5) tick();
    e_byte(8'h0A);
    for (int i = 0; i < 10; i++) e_smp(16'(i), 1'b0);
    cmp_q("p4", 0);
    check_eq("p4_done_at", at(done_q0, 0), 41);

    // Short scan then over-long scan.
    reset_dut();
    for (int i = 0; i < 4; i++)  send(16'(16'h100 + i), i == 3);
    for (int i = 0; i < 12; i++) send(16'(16'h200 + i), 1'b0);
    wait_q(0, 67);
    repeat (10) tick();
    e_byte(8'h0A);
    for (int i = 0; i < 4; i++) e_smp(16'(16'h100 + i), 1'b0);
    e_byte(8'h0A);
    for (int i = 0; i < 10; i++) e_smp(16'(16'h200 + i), 1'b0);
    e_byte(8'h0A);
    for (int i = 10; i < 12; i++) e_smp(16'(16'h200 + i), 1'b0);
    cmp_q("p5", 0);
    check_eq("p5_done0", at(done_q0, 0), 17);
    check_eq("p5_done1", at(done_q0, 1), 58);
    check_eq("p5_err0", at(err_q0, 0), 17);
    check_eq("p5_err1", at(err_q0, 1), 58);
    check_eq("p5_hdr_s11", qbyte(0, 58), 8'h0A);

    // Fill the buffer while the UART is full.
    tx_full = 1'b1;
    reset_dut();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      s_data  = 16'(k);
      s_last  = 1'b0;
      s_valid = 1'b1;
      rdy     = s_ready0;
      tick();
      if (rdy) k++;
    end
    s_valid = 1'b0;
    check_eq("bp_accepts", k, 16);
    check_eq("bp_ready_low", s_ready0, 0);
    tx_full = 1'b0;
    wait_q(0, 66);
    repeat (10) tick();
    e_byte(8'h0A);
    for (int i = 0; i < 10; i++) e_smp(16'(i), 1'b0);
    e_byte(8'h0A);
    for (int i = 10; i < 16; i++) e_smp(16'(i), 1'b0);
    cmp_q("p6", 0);
    check_eq("p6_done_at", at(done_q0, 0), 41);
    check_eq("p6_err_at", at(err_q0, 0), 41);

    // Reset in the middle of a frame.
    reset_dut();
    send(16'h123, 1'b0);
    send(16'h456, 1'b0);
    wait_q(0, 5);
    #2;
    reset = 1'b1;
    #1;
    check_eq("p7_wr_low", tx_wr0, 0);
    check_eq("p7_data_zero", tx_data0, 8'h00);
    check_eq("p7_ready_low", s_ready0, 0);
    tick(); tick();
    reset = 1'b0;
    clear_q();
    repeat (20) tick();
    check_eq("p7_flushed", q0.size(), 0);
    check_eq("p7_ready_high", s_ready0, 1);
    send(16'h7E5, 1'b1);
    wait_q(0, 5);
    repeat (5) tick();
    e_byte(8'h0A); e_smp(16'h7E5, 1'b0);
    cmp_q("p7", 0);

    check_eq("no_wr_after_full", viol, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_hex_frame_tx.md
Name: adc_hex_frame_tx

Overview:
Packs a stream of ADC samples into framed ASCII-hex text and writes it byte-wise into the UART transmit FIFO. It replaces the fixed 12-bit/4-digit, delay-chain-timed converter. This block has a generic sample width, a configurable channel count and digit case, an optional separator, and a real handshake: input valid/ready plus output backpressure from the UART FIFO full flag. It sits between the XADC sampling logic (ug480) and uart_tx_top, all in the 50 MHz domain.

Parameters:
DATA_W, 12, sample width in bits (1..32)
NIBBLES, 4, hex digits per sample; must be >= ceil(DATA_W/4); sample is zero-extended to 4*NIBBLES bits
CH_NUM, 10, samples per frame (1..255)
HEADER, 8'h0A, byte sent at the start of every frame
SEP_EN, 0, 1 = send SEP after every sample except the last of a frame
SEP, 8'h20, separator byte
UPPER, 0, 1 = digits A-F as 0x41-0x46; 0 = a-f as 0x61-0x66
BUF_DEPTH, 16, input sample buffer depth (power of 2, >= 2)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  buffer can accept a sample (= not buffer full)
s_data  in  DATA_W  sample value
s_last  in  1  sample is the last of a scan; qualified by s_valid&s_ready
tx_full  in  1  UART TX FIFO full
tx_wr  out  1  write strobe to UART TX FIFO (w_data/wr_uart of uart_tx_top)
tx_data  out  8  byte to write
frame_done  out  1  one-cycle pulse in the cycle the last byte of a frame is written
frame_err  out  1  one-cycle pulse when s_last disagrees with the channel count

Behaviour:
- Reset: buffer empty, s_ready=0 during reset then 1, tx_wr=0, tx_data=8'h00, frame_done=0, frame_err=0, FSM=IDLE, channel counter=0, digit counter=0.
- Input accept: push {s_last,s_data} when s_valid&s_ready. Simultaneous push and pop on a full buffer is not allowed: s_ready depends only on full.
- tx_wr/tx_data are registered. A byte is written in a cycle only if tx_full was 0 in the previous cycle. tx_wr must never be 1 in the cycle after tx_full=1. At most one byte per cycle.
- FSM states:
  IDLE: when the buffer is non-empty, go to HDR.
  HDR: write HEADER, go to DIG, digit index = NIBBLES-1.
  DIG: write the ASCII form of nibble[index] of the head sample, MSB first.
    - If index > 0: decrement index.
    - If index = 0: pop the sample.
      - If the frame ends, pulse frame_done with this write, go to IDLE if the buffer is otherwise empty, else go to HDR.
      - Else go to SEP if SEP_EN, or to WAITS.
  SEP: write SEP, go to WAITS.
  WAITS: when the buffer is non-empty, go to DIG with index=NIBBLES-1. This allows a gap while waiting for the next sample.
- Frame end is the earlier of the two conditions:
  - channel counter = CH_NUM-1
  - head sample has last=1
  The channel counter resets to 0 at frame end, otherwise it increments per sample.
- frame_err pulses with the frame_done write if exactly one of the two conditions is true (short scan or over-long scan). The frame still closes.
- Stall: in any write state, when tx_full blocks the write, hold state, index and head sample. No byte is lost or repeated.
- ASCII: n<10 -> 8'h30+n; else 8'h37+n (UPPER=1) or 8'h57+n (UPPER=0).
- Byte count per full frame: 1 + CH_NUM*NIBBLES + (SEP_EN ? CH_NUM-1 : 0).
- Reset mid-frame: the partial frame is abandoned and the buffer is cleared. The next frame starts with HEADER.

Decomposition:
- Package adc_hex_pkg holds:
  - state encoding constants: IDLE, HDR, DIG, SEP, WAITS
  - function nib2ascii(nibble, upper)
  - constants ASCII_0=8'h30, ASCII_A_UP=8'h37, ASCII_A_LO=8'h57
- One sub-module: sync_fifo (width DATA_W+1, depth BUF_DEPTH, first-word fall-through, full/empty flags, asynchronous active-high reset).

Test Plan:
- Defaults, tx_full=0, 10 samples 12'h000..12'h009, last on the 10th -> 41 bytes: 0A, "0000".."0009". frame_done once on byte 41, frame_err never.
- Sample 12'hABC, UPPER=0 then UPPER=1 -> "0abc" then "0ABC". DATA_W=16, NIBBLES=4, sample 16'hF00D -> "f00d".
- SEP_EN=1, CH_NUM=3, samples 1,2,3 -> 0A "0001" 20 "0002" 20 "0003". No trailing separator. 15 bytes.
- Drive tx_full high for 5 cycles at every 3rd byte -> byte sequence identical to the unstalled run. No tx_wr in the cycle after tx_full=1.
- CH_NUM=10 with s_last on the 4th sample, then 12 samples with no s_last:
  - first frame is 17 bytes with frame_err pulsed
  - next frame closes after 10 samples with frame_err pulsed
  - a new HEADER is sent before sample 11
- Hold s_valid for 20 samples with tx_full=1 -> s_ready drops after 16 accepts. Release -> all 16 samples emitted in order. Assert reset mid-frame -> tx_wr=0 at once, next output starts with 8'h0A.
